// File: rtl/csr_pkg.sv
// Shared definitions for the CSR read-modify-write engine: funct3 codes,
// privilege levels, the sequencer state type and the write-intent decode.
package csr_pkg;

  localparam logic [2:0] CSR_RW  = 3'b001;
  localparam logic [2:0] CSR_RS  = 3'b010;
  localparam logic [2:0] CSR_RC  = 3'b011;
  localparam logic [2:0] CSR_RWI = 3'b101;
  localparam logic [2:0] CSR_RSI = 3'b110;
  localparam logic [2:0] CSR_RCI = 3'b111;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // addr[11:10] value marking the read-only CSR space
  localparam logic [1:0] CSR_RO_SPACE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_rmw_state_e;

  // Set/clear forms with a zero source never write; swap forms always do.
  function automatic logic csr_wr_intent(input logic [2:0] funct3, input logic src_is_x0);
    case (funct3)
      CSR_RW, CSR_RWI:                  csr_wr_intent = 1'b1;
      CSR_RS, CSR_RC, CSR_RSI, CSR_RCI: csr_wr_intent = ~src_is_x0;
      default:                          csr_wr_intent = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_rmw_op.sv
// Combinational modify step: merges the old CSR value with the source
// operand according to funct3 and reports whether a write is wanted.
module csr_rmw_op
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  input  logic [2:0]      funct3,
  input  logic            src_is_x0,
  output logic [XLEN-1:0] new_val,
  output logic            wr_intent
);

  always_comb begin
    wr_intent = csr_wr_intent(funct3, src_is_x0);
    // funct3[1:0] selects swap/set/clear; the immediate forms share it
    case (funct3[1:0])
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = src;
    endcase
  end

endmodule

// File: rtl/csr_rmw_unit.sv
// CSR read-modify-write sequencer: accepts one CSR instruction, checks
// legality, reads/modifies/writes the CSR file and returns the old value.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | ready for a request; legality decided on accept
//   ST_READ  | csr_re issued, read data arrives next cycle
//   ST_WRITE | old value captured, csr_we issued if a write is intended
//   ST_RESP  | response held until resp_ready
module csr_rmw_unit
  import csr_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit PRIV_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_src_is_x0,
  input  logic            req_rd_is_x0,
  input  logic [1:0]      req_priv,
  output logic            csr_re,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal
);

  csr_rmw_state_e state_q, state_d;

  logic [2:0]      funct3_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] old_q;
  logic            src_is_x0_q;
  logic            rd_skip_q;
  logic            illegal_q;

  logic            accept;
  logic            req_wr_intent;
  logic            req_rd_skip;
  logic            req_illegal;
  logic [XLEN-1:0] op_old;
  logic [XLEN-1:0] op_new;
  logic            op_wr_intent;

  assign accept        = (state_q == ST_IDLE) & req_valid & ~rst;
  assign req_wr_intent = csr_wr_intent(req_funct3, req_src_is_x0);
  assign req_rd_skip   = ((req_funct3 == CSR_RW) | (req_funct3 == CSR_RWI)) & req_rd_is_x0;
  assign req_illegal   = (req_funct3[1:0] == 2'b00)
                       | (PRIV_CHECK & (req_priv < req_addr[9:8]))
                       | ((req_addr[11:10] == CSR_RO_SPACE) & req_wr_intent);

  // A skipped read feeds zero so the returned old value is zero too.
  assign op_old = rd_skip_q ? '0 : csr_rdata;

  csr_rmw_op #(.XLEN(XLEN)) u_op (
    .old_val   (op_old),
    .src       (src_q),
    .funct3    (funct3_q),
    .src_is_x0 (src_is_x0_q),
    .new_val   (op_new),
    .wr_intent (op_wr_intent)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q    <= 3'd0;
      addr_q      <= 12'd0;
      src_q       <= '0;
      old_q       <= '0;
      src_is_x0_q <= 1'b0;
      rd_skip_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      funct3_q    <= req_funct3;
      addr_q      <= req_addr;
      src_q       <= req_src;
      old_q       <= '0;
      src_is_x0_q <= req_src_is_x0;
      rd_skip_q   <= req_rd_skip;
      illegal_q   <= req_illegal;
    end else if (state_q == ST_WRITE) begin
      old_q       <= op_old;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_illegal)      state_d = ST_RESP;
          else if (req_rd_skip) state_d = ST_WRITE;
          else                  state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes are gated by rst so nothing fires in a reset cycle.
  always_comb begin
    req_ready    = (state_q == ST_IDLE) & ~rst;
    csr_re       = (state_q == ST_READ) & ~rst;
    csr_raddr    = addr_q;
    csr_we       = (state_q == ST_WRITE) & op_wr_intent & ~rst;
    csr_waddr    = addr_q;
    csr_wdata    = (state_q == ST_WRITE) ? op_new : '0;
    resp_valid   = (state_q == ST_RESP) & ~rst;
    resp_rdata   = resp_valid ? old_q : '0;
    resp_illegal = resp_valid & illegal_q;
  end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Randomized and directed bench for csr_rmw_unit (XLEN=64) with a simple
// CSR-file model and a reference model of the RMW rules.
module tb_csr_rmw_unit;
  import csr_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = 3'd0;
  logic [11:0]     req_addr = 12'd0;
  logic [XLEN-1:0] req_src = '0;
  logic            req_src_is_x0 = 1'b0;
  logic            req_rd_is_x0 = 1'b0;
  logic [1:0]      req_priv = 2'd0;
  logic            csr_re;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata = '0;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] mem     [4096];
  logic [XLEN-1:0] ref_mem [4096];
  logic            bd_we = 1'b0;
  logic [11:0]     bd_addr = 12'd0;
  logic [XLEN-1:0] bd_data = '0;

  logic [11:0] pool [10] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'hC00,
                             12'hC01, 12'h100, 12'h180, 12'h7C0, 12'hF11};

  csr_rmw_unit #(.XLEN(XLEN), .PRIV_CHECK(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_src       (req_src),
    .req_src_is_x0 (req_src_is_x0),
    .req_rd_is_x0  (req_rd_is_x0),
    .req_priv      (req_priv),
    .csr_re        (csr_re),
    .csr_raddr     (csr_raddr),
    .csr_rdata     (csr_rdata),
    .csr_we        (csr_we),
    .csr_waddr     (csr_waddr),
    .csr_wdata     (csr_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_illegal  (resp_illegal)
  );

  always #5 clk = ~clk;

  // CSR file: one-cycle read latency, plus a backdoor for preloading
  always @(posedge clk) begin
    if (bd_we)  mem[bd_addr]   <= bd_data;
    if (csr_we) mem[csr_waddr] <= csr_wdata;
    if (csr_re) csr_rdata      <= mem[csr_raddr];
  end

  task automatic check(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_csr(input logic [11:0] addr, input logic [XLEN-1:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = addr; bd_data = val;
    ref_mem[addr] = val;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_req(input logic [2:0] f3, input logic [11:0] addr, input logic [XLEN-1:0] src,
                         input bit sx0, input bit rdx0, input logic [1:0] priv, input int hold);
    string op;
    bit ill, do_rd, do_wr, got;
    logic [XLEN-1:0] old, wval, exp_rdata;
    int exp_lat, k, re_n, we_n, we_k;

    case (f3)
      3'b001, 3'b101: op = "swap";
      3'b010, 3'b110: op = "set";
      3'b011, 3'b111: op = "clear";
      default:        op = "bad";
    endcase
    do_wr = (op == "swap") || (op != "bad" && !sx0);
    ill   = (op == "bad") || (priv < addr[9:8]) || (addr[11:10] == 2'b11 && do_wr);
    do_rd = !ill && !(op == "swap" && rdx0);
    if (ill) do_wr = 0;
    old       = ref_mem[addr];
    wval      = (op == "set") ? (old | src) : (op == "clear") ? (old & ~src) : src;
    exp_rdata = do_rd ? old : '0;
    exp_lat   = ill ? 1 : (do_rd ? 3 : 2);
    if (do_wr) ref_mem[addr] = wval;

    @(negedge clk);
    req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_src = src;
    req_src_is_x0 = sx0; req_rd_is_x0 = rdx0; req_priv = priv;
    check("idle_ready", XLEN'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1; re_n = 0; we_n = 0; we_k = 0; got = 0;
    while (!got && k <= 8) begin
      if (csr_re) begin
        re_n++;
        check("raddr", XLEN'(csr_raddr), XLEN'(addr));
      end
      if (csr_we) begin
        we_n++; we_k = k;
        check("waddr", XLEN'(csr_waddr), XLEN'(addr));
        check("wdata", csr_wdata, wval);
      end
      check("busy_ready", XLEN'(req_ready), 0);
      if (resp_valid) got = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("resp_seen", XLEN'(got), 1);
    if (got) begin
      check("resp_lat", XLEN'(k), XLEN'(exp_lat));
      check("resp_rdata", resp_rdata, exp_rdata);
      check("resp_illegal", XLEN'(resp_illegal), XLEN'(ill));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (csr_we) we_n++;
        check("hold_valid", XLEN'(resp_valid), 1);
        check("hold_rdata", resp_rdata, exp_rdata);
        check("hold_illegal", XLEN'(resp_illegal), XLEN'(ill));
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("resp_drop", XLEN'(resp_valid), 0);
      check("back_ready", XLEN'(req_ready), 1);
    end
    check("re_count", XLEN'(re_n), XLEN'(do_rd));
    check("we_count", XLEN'(we_n), XLEN'(do_wr));
    if (do_wr) check("we_lat", XLEN'(we_k), do_rd ? 2 : 1);
  endtask

  initial begin
    logic [11:0] a;
    logic [2:0]  f3;
    bit          sx0;
    logic [XLEN-1:0] s;

    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    for (int i = 0; i < 10; i++) set_csr(pool[i], {$urandom, $urandom});

    @(negedge clk);
    check("rst_ready", XLEN'(req_ready), 0);
    check("rst_re", XLEN'(csr_re), 0);
    check("rst_we", XLEN'(csr_we), 0);
    check("rst_resp_valid", XLEN'(resp_valid), 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_wdata", csr_wdata, 0);
    rst = 1'b0;

    set_csr(12'h300, 64'hF0);
    run_req(CSR_RS, 12'h300, 64'h0F, 0, 0, PRIV_M, 0);
    check("case1_result", ref_mem[12'h300], 64'hFF);
    set_csr(12'h341, 64'h1234);
    run_req(CSR_RC, 12'h341, 64'h0, 1, 0, PRIV_M, 0);
    run_req(CSR_RW, 12'h340, 64'hDEAD, 0, 1, PRIV_M, 0);
    run_req(CSR_RW, 12'hC00, 64'h55, 0, 0, PRIV_M, 0);
    set_csr(12'hC00, 64'hABCD);
    run_req(CSR_RS, 12'hC00, 64'h0, 1, 0, PRIV_U, 0);
    run_req(CSR_RS, 12'h300, 64'h1, 0, 0, PRIV_U, 0);
    run_req(3'b100, 12'h300, 64'h3, 0, 0, PRIV_M, 5);
    run_req(CSR_RWI, 12'h305, 64'h7, 0, 0, PRIV_M, 5);
    run_req(CSR_RS, 12'h180, 64'h2, 0, 0, PRIV_S, 1);
    set_csr(12'h300, 64'hA5A5_0000_0000_00F0);
    run_req(CSR_RS, 12'h300, 64'h0F00_0000_0000_000F, 0, 0, PRIV_M, 0);
    check("case1_64_result", ref_mem[12'h300], 64'hAFA5_0000_0000_00FF);

    // reset while in WRITE: the write must be dropped
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = CSR_RS; req_addr = 12'h305; req_src = 64'hFFFF;
    req_src_is_x0 = 1'b0; req_rd_is_x0 = 1'b0; req_priv = PRIV_M;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_we", XLEN'(csr_we), 0);
    check("rstw_ready", XLEN'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw_re", XLEN'(csr_re), 0);
    check("rstw_we_after", XLEN'(csr_we), 0);
    check("rstw_raddr", XLEN'(csr_raddr), 0);
    check("rstw_waddr", XLEN'(csr_waddr), 0);
    check("rstw_wdata", csr_wdata, 0);
    check("rstw_resp_valid", XLEN'(resp_valid), 0);
    check("rstw_resp_rdata", resp_rdata, 0);
    check("rstw_resp_illegal", XLEN'(resp_illegal), 0);
    check("rstw_ready_after", XLEN'(req_ready), 1);
    run_req(CSR_RS, 12'h305, 64'h0, 1, 0, PRIV_M, 0);

    for (int i = 0; i < 80; i++) begin
      a   = pool[$urandom_range(0, 9)];
      f3  = 3'($urandom_range(0, 7));
      sx0 = ($urandom_range(0, 3) == 0);
      s   = sx0 ? '0 : {$urandom, $urandom};
      run_req(f3, a, s, sx0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
              $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
